// File: rtl/rf_bypass_sb.sv
// Two-read/two-write register file with same-cycle write bypass, optional
// hardwired zero register and a per-register busy scoreboard with live count.
module rf_bypass_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [ADDR_W:0]              cnt_q, cnt_d;

    logic w0_v, w1_v, rsv_v;
    logic set_new, clr0, clr1;

    // Requests aimed at the hardwired zero register are squashed at the source.
    assign w0_v  = w0_en  && !(ZERO_REG && w0_addr  == '0);
    assign w1_v  = w1_en  && !(ZERO_REG && w1_addr  == '0);
    assign rsv_v = rsv_en && !(ZERO_REG && rsv_addr == '0);

    function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
        if (ZERO_REG && a == '0)      return '0;
        else if (w1_en && w1_addr == a) return w1_data;
        else if (w0_en && w0_addr == a) return w0_data;
        else                            return regs_q[a];
    endfunction

    function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
        if (ZERO_REG && a == '0)                             return 1'b0;
        else if ((w0_en && w0_addr == a) || (w1_en && w1_addr == a)) return 1'b0;
        else                                                 return busy_q[a];
    endfunction

    always_comb begin
        rs_data = rd_data(rs_addr);
        rt_data = rd_data(rt_addr);
        rs_busy = rd_busy(rs_addr);
        rt_busy = rd_busy(rt_addr);
    end

    // w1 is applied after w0 so it wins a collision; a reservation is applied
    // last so a new producer stays outstanding over a same-cycle write.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (w0_v) begin
            regs_d[w0_addr] = w0_data;
            busy_d[w0_addr] = 1'b0;
        end
        if (w1_v) begin
            regs_d[w1_addr] = w1_data;
            busy_d[w1_addr] = 1'b0;
        end
        if (rsv_v) busy_d[rsv_addr] = 1'b1;
    end

    // Incremental popcount: a bit only counts as cleared if it was set, is not
    // re-reserved this cycle, and was not already counted by the other port.
    always_comb begin
        set_new = rsv_v && !busy_q[rsv_addr];
        clr0    = w0_v && busy_q[w0_addr] && !(rsv_v && rsv_addr == w0_addr);
        clr1    = w1_v && busy_q[w1_addr] && !(rsv_v && rsv_addr == w1_addr)
                  && !(clr0 && w0_addr == w1_addr);
        cnt_d   = cnt_q + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr0) - (ADDR_W+1)'(clr1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;
endmodule

// File: doc/rf_bypass_sb.md
# rf_bypass_sb

Parametrised register file for the pipelined single-cycle-successor datapath: two combinational read ports, two write ports, write-to-read bypass, a hardwired zero register and a per-register busy scoreboard for hazard detection. It sits between decode (reads, reservations) and writeback (writes). Unlike the previous unclocked-latch file, all state updates on the rising clock edge and the file is fully cleared by reset.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes and reservations; 0: register 0 is ordinary

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- rs_addr  in  ADDR_W  read port A address
- rt_addr  in  ADDR_W  read port B address
- rs_data  out  DATA_W  read port A data (combinational)
- rt_data  out  DATA_W  read port B data (combinational)
- rs_busy  out  1  register at rs_addr has an outstanding reservation
- rt_busy  out  1  register at rt_addr has an outstanding reservation
- w0_en  in  1  write port 0 enable
- w0_addr  in  ADDR_W  write port 0 address
- w0_data  in  DATA_W  write port 0 data
- w1_en  in  1  write port 1 enable (higher priority)
- w1_addr  in  ADDR_W  write port 1 address
- w1_data  in  DATA_W  write port 1 data
- rsv_en  in  1  mark rsv_addr busy (pending producer issued)
- rsv_addr  in  ADDR_W  register to reserve
- busy_cnt  out  ADDR_W+1  number of registers currently busy (registered)

## Operation
- Storage: 2^ADDR_W x DATA_W registers plus 2^ADDR_W busy bits and a busy_cnt counter.
- Write (rising edge, rst=0): w0_en writes w0_data to w0_addr; w1_en writes w1_data to w1_addr; same address on both: w1 value stored, w0 dropped.
- Any write clears the busy bit of its address.
- Reservation (rising edge): rsv_en sets busy bit of rsv_addr. Reservation and write to the same address in one cycle: busy ends set (new producer outstanding), data still written.
- ZERO_REG=1: writes and reservations to address 0 ignored; rs_data/rt_data = 0 and rs_busy/rt_busy = 0 for address 0, bypass included.
- Read data: if w1_en and w1_addr matches -> w1_data; else if w0_en and w0_addr matches -> w0_data; else stored value. Zero-register rule overrides.
- Read busy: stored busy bit, forced 0 if any enabled write targets that address this cycle; a same-cycle reservation is not visible until the next cycle.
- busy_cnt: next value = popcount of next busy vector; maintained incrementally (+1 per newly set bit, -1 per newly cleared bit; two writes to distinct busy registers clear two). Never exceeds 2^ADDR_W.
- Redundant reserve of an already-busy register: no change to count. Write to a non-busy register: no change to count.

## Timing
- Reset: on rising edge with rst=1, all registers 0, all busy bits 0, busy_cnt 0; overrides any write/reservation in that cycle. Reset mid-operation discards pending reservations.
- Read latency: 0 cycles (combinational from addresses and write ports).
- Write latency: data visible via bypass same cycle, from storage the cycle after the edge.
- Reservation latency: busy visible 1 cycle after the rsv_en edge; busy_cnt updated on the same edge.
- No handshake/backpressure; every enabled request is accepted every cycle.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst one cycle -> rs_addr=5 gives 0x00000000, busy_cnt=0.
- Dual write collision: w0(r7,0x11111111), w1(r7,0x22222222) same edge -> rs_data(r7)=0x22222222 both during (bypass) and after the edge.
- Zero register: w1(r0,0xFFFFFFFF) plus rsv_en r0 -> rs_data=0, rs_busy=0, busy_cnt unchanged.
- Scoreboard: reserve r3, r4, r3 on three edges -> busy_cnt=2; w0(r3) and w1(r4) same edge -> rs_busy(r3)=0 during that cycle, busy_cnt=0 after.
- Reserve+write same address same edge on r9 (previously busy) -> r9 holds new data, rs_busy(r9)=1 after, busy_cnt unchanged.
- Full: reserve all 31 non-zero registers (ADDR_W=5, ZERO_REG=1) -> busy_cnt=31; ZERO_REG=0 build reserving all 32 -> busy_cnt=32, no wrap.
